core_seq: RTL and testbench

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_core_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// core_seq: multi-cycle sequencer for a small RV32-style core.
// It walks each instruction through FETCH / DECODE / EXEC / MEM / WB and
// produces the fetch and data handshakes and the IR, register-file and PC
// write strobes. It also keeps the retired-instruction counter and a sticky trap.
//
// Ports
//   clk                  single clock, rising edge
//   rst                  asynchronous active-high reset
//   en                   run enable; sampled in IDLE and at retire
//   opcode[6:0]          instr_raw[6:0] from the instruction register
//   br_taken             branch compare result, valid in EXEC
//   imem_req/imem_ready  instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready  data access handshake (we=1 for stores)
//   ir_we                instruction register load strobe
//   rf_we                register file write strobe
//   pc_we                PC update strobe; one pulse per retired instruction
//   pc_sel[1:0]          00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1
//   instret[31:0]        retired-instruction counter
//   trap/trap_cause[1:0] sticky trap; 01 illegal, 10 imem timeout, 11 dmem timeout
//
// state  | meaning
// IDLE   | stopped, waiting for en
// FETCH  | imem_req held until imem_ready; loads IR
// DECODE | one cycle; classifies opcode or traps as illegal
// EXEC   | one cycle; branches retire here
// MEM    | dmem_req held until dmem_ready; stores retire here
// WB     | one cycle register write and retire
// TRAP   | absorbing until reset

module core_seq #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // Instruction class captured in DECODE, so later states do not depend
    // on the IR output staying stable.
    typedef enum logic [2:0] {
        K_ALU,
        K_LOAD,
        K_STORE,
        K_BRANCH,
        K_JAL,
        K_JALR
    } kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [1:0]  cause_q, cause_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] instret_q, instret_d;

    logic        retire;
    logic        legal;
    kind_t       dec_kind;
    logic        wait_last;

    // Opcode classification.
    always_comb begin
        legal    = 1'b1;
        dec_kind = K_ALU;
        case (opcode)
            OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC: dec_kind = K_ALU;
            OP_LOAD:                           dec_kind = K_LOAD;
            OP_STORE:                          dec_kind = K_STORE;
            OP_BRANCH:                         dec_kind = K_BRANCH;
            OP_JAL:                            dec_kind = K_JAL;
            OP_JALR:                           dec_kind = K_JALR;
            default:                           legal    = 1'b0;
        endcase
    end

    // The wait counter reaches TIMEOUT on this edge if ready stays low.
    // A ready in this same cycle is checked first, so ready wins.
    assign wait_last = (wait_cnt_q == (TIMEOUT - 8'd1));

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cause_d  = cause_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_PLUS4;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_last) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    kind_d  = dec_kind;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_LOAD, K_STORE: state_d = S_MEM;
                    K_BRANCH: begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? PC_REL : PC_PLUS4;
                        retire = 1'b1;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (kind_q == K_STORE);
                if (dmem_ready) begin
                    if (kind_q == K_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_last) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                case (kind_q)
                    K_JAL:   pc_sel = PC_REL;
                    K_JALR:  pc_sel = PC_REG;
                    default: pc_sel = PC_PLUS4;
                endcase
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire) state_d = en ? S_FETCH : S_IDLE;
    end

    // Wait counter: cleared on entry to FETCH or MEM, counts ready-low cycles.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
            wait_cnt_d = 8'd0;
        end else if ((state_q == S_FETCH && !imem_ready) ||
                     (state_q == S_MEM && !dmem_ready)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // pc_we is never asserted in TRAP, so the counter freezes there.
    always_comb begin
        instret_d = instret_q;
        if (pc_we) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            kind_q     <= K_ALU;
            cause_q    <= 2'b00;
            wait_cnt_q <= 8'd0;
            instret_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cause_q    <= cause_d;
            wait_cnt_q <= wait_cnt_d;
            instret_q  <= instret_d;
        end
    end

    assign instret    = instret_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    logic        clk, rst, en, br_taken, imem_ready, dmem_ready;
    logic [6:0]  opcode;

    logic        imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, trap;
    logic [1:0]  pc_sel, trap_cause;
    logic [31:0] instret;

    logic        imem_req_4, dmem_req_4, dmem_we_4, ir_we_4, rf_we_4, pc_we_4, trap_4;
    logic [1:0]  pc_sel_4, trap_cause_4;
    logic [31:0] instret_4;

    int n_assert = 0;
    int n_fail   = 0;

    core_seq dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .br_taken(br_taken),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    core_seq #(.TIMEOUT(8'd4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .br_taken(br_taken),
        .imem_req(imem_req_4), .imem_ready(imem_ready),
        .dmem_req(dmem_req_4), .dmem_we(dmem_we_4), .dmem_ready(dmem_ready),
        .ir_we(ir_we_4), .rf_we(rf_we_4), .pc_we(pc_we_4), .pc_sel(pc_sel_4),
        .instret(instret_4), .trap(trap_4), .trap_cause(trap_cause_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; opcode = OP_ALU; br_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #12;
        // reset state
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_strobes", {ir_we, rf_we, pc_we}, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_instret", instret, 0);
        chk("rst_trap", {trap, trap_cause}, 0);
        rst = 1'b0;
        tick();
        chk("idle_hold", imem_req, 0);

        // ALU stream, zero-wait fetch
        en = 1'b1; imem_ready = 1'b1; opcode = OP_ALU;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("alu_ir_we", ir_we, (i % 4 == 0));
            chk("alu_pc_we", pc_we, (i % 4 == 3));
            chk("alu_rf_we", rf_we, (i % 4 == 3));
            tick();
        end
        chk("alu_instret3", instret, 3);
        en = 1'b0;
        #1;
        chk("en_drop_req_kept", imem_req, 1);
        tick(); tick(); tick();
        chk("en_drop_wb", pc_we, 1);
        tick();
        chk("en_drop_idle", imem_req, 0);
        chk("instret4", instret, 4);
        tick();
        chk("idle_stays", imem_req, 0);

        // load with three wait cycles
        opcode = OP_LOAD; en = 1'b1;
        tick();
        chk("ld_ir_we", ir_we, 1);
        en = 1'b0;
        tick(); tick();
        chk("ld_exec_no_dreq", dmem_req, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) dmem_ready = 1'b1;
            #1;
            chk("ld_dmem_req", dmem_req, 1);
            chk("ld_dmem_we", dmem_we, 0);
            chk("ld_mem_no_pc_we", pc_we, 0);
            tick();
        end
        dmem_ready = 1'b0;
        chk("ld_wb_rf_we", rf_we, 1);
        chk("ld_wb_pc_we", pc_we, 1);
        tick();
        chk("ld_instret", instret, 5);
        chk("ld_idle", imem_req, 0);

        // store, zero-wait
        opcode = OP_STORE; en = 1'b1;
        tick();
        en = 1'b0;
        tick(); tick(); tick();
        dmem_ready = 1'b1;
        #1;
        chk("st_dmem_req", dmem_req, 1);
        chk("st_dmem_we", dmem_we, 1);
        chk("st_pc_we", pc_we, 1);
        chk("st_rf_we", rf_we, 0);
        tick();
        dmem_ready = 1'b0;
        chk("st_instret", instret, 6);
        chk("st_idle", dmem_req, 0);

        // branch taken, then not taken
        opcode = OP_BRANCH; br_taken = 1'b1; en = 1'b1;
        tick(); tick(); tick();
        chk("br1_pc_we", pc_we, 1);
        chk("br1_pc_sel", pc_sel, 2'b01);
        chk("br1_rf_we", rf_we, 0);
        tick();
        chk("br_refetch", ir_we, 1);
        br_taken = 1'b0; en = 1'b0;
        tick(); tick();
        chk("br0_pc_we", pc_we, 1);
        chk("br0_pc_sel", pc_sel, 2'b00);
        chk("br0_rf_we", rf_we, 0);
        tick();
        chk("br_instret", instret, 8);

        // JAL then JALR
        opcode = OP_JAL; en = 1'b1;
        tick(); tick(); tick();
        opcode = OP_JALR;
        tick();
        chk("jal_pc_sel", pc_sel, 2'b01);
        chk("jal_rf_we", rf_we, 1);
        tick();
        en = 1'b0;
        tick(); tick(); tick();
        chk("jalr_pc_sel", pc_sel, 2'b10);
        tick();
        chk("jalr_instret", instret, 10);

        // instret wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap_preload", instret, 32'hFFFF_FFFF);
        opcode = OP_BRANCH; br_taken = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        tick(); tick();
        chk("wrap_pc_we", pc_we, 1);
        tick();
        chk("wrap_instret", instret, 0);

        // reset mid-MEM
        opcode = OP_LOAD; en = 1'b1;
        tick();
        en = 1'b0;
        tick(); tick(); tick();
        chk("mid_mem_req", dmem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_dreq", dmem_req, 0);
        chk("rst_async_strobes", {ir_we, rf_we, pc_we}, 0);
        tick();
        rst = 1'b0;
        dmem_ready = 1'b1;
        #1;
        chk("rst_instret_clr", instret, 0);
        tick();
        chk("rst_idle_ignore_dready", dmem_req, 0);
        chk("rst_idle_imem", imem_req, 0);
        dmem_ready = 1'b0;

        // illegal opcode trap
        opcode = OP_FENCE; en = 1'b1;
        tick(); tick();
        chk("ill_decode_no_trap", trap, 0);
        tick();
        chk("ill_trap", trap, 1);
        chk("ill_cause", trap_cause, 2'b01);
        for (int k = 0; k < 4; k++) begin
            imem_ready = k[0];
            #1;
            chk("trap_quiet", {imem_req, ir_we, pc_we, dmem_req}, 0);
            tick();
        end
        chk("trap_sticky", {trap, trap_cause}, 3'b101);
        chk("trap_instret", instret, 0);
        rst = 1'b1;
        #1;
        chk("trap_rst_clear", {trap, trap_cause}, 0);
        rst = 1'b0;

        // fetch timeout on TIMEOUT=4 instance
        opcode = OP_ALU; imem_ready = 1'b0; en = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("to_imem_req4", imem_req_4, 1);
            chk("to_no_trap4", trap_4, 0);
            tick();
        end
        chk("to_trap4", trap_4, 1);
        chk("to_cause4", trap_cause_4, 2'b10);
        chk("to_req_drop4", imem_req_4, 0);
        chk("to_default_waits", {trap, imem_req}, 2'b01);

        // ready on the last wait cycle wins
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) imem_ready = 1'b1;
            #1;
            chk("race_ir_we4", ir_we_4, (k == 3));
            tick();
        end
        chk("race_no_trap4", trap_4, 0);
        en = 1'b0;
        tick(); tick();
        chk("race_wb4", {rf_we_4, pc_we_4, pc_sel_4}, 4'b1100);
        tick();
        chk("race_instret4", instret_4, 1);

        // data timeout on TIMEOUT=4 instance
        opcode = OP_LOAD; en = 1'b1;
        tick();
        en = 1'b0;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk("dto_dmem_req4", dmem_req_4, 1);
            chk("dto_dmem_we4", dmem_we_4, 0);
            tick();
        end
        chk("dto_trap4", {trap_4, trap_cause_4}, 3'b111);
        chk("dto_req_drop4", dmem_req_4, 0);
        chk("dto_default_waits", dmem_req, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Guards against a hang in the directed sequence.
    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
